hazard_scoreboard_ctrlr: RTL
============================

// Module: hazard_scoreboard_ctrlr
// PURPOSE
//  Parametrised successor to the decode-stage hazard logic. A per-register countdown scoreboard
//  replaces the fixed E/M/W address compares. It tracks in-flight writes of variable latency
//  (ALU, load, multi-cycle mul/div) and drives the decode stall. It also drives the rs/rt
//  bypass-source selects for any number of forwarding stages.
//  Sits beside the decode stage; the stall gates the IF/ID enable; the selects drive the operand muxes.
// PARAMETERS
//  REG_ADDR_W   5   register address width; NUM_REGS = 2**REG_ADDR_W; register 0 is never tracked
//  FWD_STAGES   3   number of bypass sources; stage 1 is nearest to execute, FWD_STAGES is writeback
//  MAX_LAT      4   largest legal i_lat value
//  CNT_W        $clog2(MAX_LAT+FWD_STAGES+1)   scoreboard counter width (derived)
//  FSEL_W       $clog2(FWD_STAGES+1)           forward-select width (derived)
// PORTS
//  clock        in   1           rising-edge clock
//  reset        in   1           asynchronous, active-high; clears all state
//  i_valid      in   1           decode holds an instruction
//  i_kill       in   1           squash the decode instruction: no issue, no stall
//  i_flush      in   1           back-end flush: clear the whole scoreboard at the next edge
//  i_rs_addr    in   REG_ADDR_W  source rs
//  i_rt_addr    in   REG_ADDR_W  source rt
//  i_rs_used    in   1           rs is read (0 for jumps and lui)
//  i_rt_used    in   1           rt is read (0 for I-type ALU; 1 for store data)
//  i_dst_we     in   1           the instruction writes a register
//  i_dst_addr   in   REG_ADDR_W  destination register (rd or rt)
//  i_lat        in   CNT_W       cycles before the result reaches bypass stage 1 (ALU=0, load=1)
//  o_stall      out  1           hold decode and insert a bubble
//  o_rs_fwd     out  FSEL_W      0 = register file; k = bypass from stage k
//  o_rt_fwd     out  FSEL_W      same encoding, for rt
//  o_idle       out  1           no register pending
// BEHAVIOUR
//  - State: cnt[r] for r = 1..NUM_REGS-1. cnt[0] is hardwired to 0. On reset every cnt = 0.
//  - Every edge, each nonzero cnt decrements by 1.
//  - issue = i_valid & ~i_kill & ~o_stall & ~i_flush. When issue & i_dst_we & i_dst_addr != 0,
//    cnt[dst] <= i_lat + FWD_STAGES. This load overrides the decrement.
//  - Operand state, from current cnt only; the issuing instruction never sees itself:
//    - cnt == 0: fwd = 0, value is in the register file.
//    - 1 <= cnt <= FWD_STAGES: fwd = FWD_STAGES - cnt + 1.
//    - cnt > FWD_STAGES: result not yet produced (RAW).
//  - o_stall = i_valid & ~i_kill & (RAW on a used source | WAW).
//    WAW = i_dst_we & cnt[dst] > i_lat + FWD_STAGES; it blocks an out-of-order overwrite.
//  - o_stall, o_rs_fwd and o_rt_fwd are combinational. The fwd outputs are 0 when the source is unused.
//    Reset values: o_stall 0, fwd 0, o_idle 1.
//  - i_flush: all cnt <= 0 at the next edge. It beats issue and decrement in the same cycle.
//    The stall is forced to 0 that cycle.
//  - Stall cycles do not freeze the counters; pending writes keep draining.
//  - i_lat > MAX_LAT is illegal; the block clamps it to MAX_LAT.
//  - A reset asserted mid-operation clears everything asynchronously. No partial state survives.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds output o_stall_cycles [31:0]. It counts cycles where o_stall=1,
//  saturates at 32'hFFFFFFFF, and is cleared by reset only.
//  HAZARD_STATS_EN undefined: the port and counter do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package hazard_pkg: FSEL_REGFILE=0 constant, lat encodings LAT_ALU=0, LAT_LOAD=1, LAT_MULDIV=MAX_LAT.
//  - Sub-module hazard_sb_entry: one countdown counter with load/decrement/clear and ready/fwd decode.
//    It is instantiated NUM_REGS-1 times by a generate loop.
//  - Top level: source and destination muxes over the entries, stall reduction, optional stats counter.
// TESTING (defaults, ALU=0, load=1)
//  1. add r3 issued, then sub r4,r3 next cycle -> no stall, o_rs_fwd=1. The cycle after: fwd=2, then 3, then 0.
//  2. lw r5, then add r6,r5 immediately -> exactly 1 stall cycle, then issue with o_rs_fwd=1.
//  3. mul r7 (i_lat=4), then add r7 (i_lat=0) -> WAW stall until cnt[r7] <= 3.
//     r7 ends holding the add's countdown.
//  4. Writes to r0 -> never tracked; o_idle stays 1; consumers of r0 get fwd=0, no stall.
//  5. lw r5 pending, i_flush with a dependent instruction in decode -> no stall that cycle.
//     All cnt=0 next cycle; o_idle=1.
//  6. HAZARD_STATS_EN: scenario 2 twice -> o_stall_cycles=2. Assert reset mid-load -> counter 0, o_idle=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard: bypass-select and latency encodings.
package hazard_pkg;

    localparam int DEFAULT_MAX_LAT = 4;

    // Forward-select value meaning "read the register file"
    localparam int FSEL_REGFILE = 0;

    // Result latencies, in cycles before the value reaches bypass stage 1
    localparam int LAT_ALU    = 0;
    localparam int LAT_LOAD   = 1;
    localparam int LAT_MULDIV = DEFAULT_MAX_LAT;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown of cycles until its register's pending write retires,
// with ready/forward-source decode of the current count.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES = 3,
    parameter int CNT_W      = 3,
    parameter int FSEL_W     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic [CNT_W-1:0]  load_val,
    output logic [CNT_W-1:0]  cnt,
    output logic              pending,
    output logic              raw,
    output logic [FSEL_W-1:0] fwd
);

    // NOTE: sequential state uses non-blocking assignments; the async reset is in the sensitivity
    // list, while flush is an ordinary synchronous clear that outranks load and decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign pending = (cnt != '0);
    assign raw     = (cnt > CNT_W'(FWD_STAGES));

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        fwd = FSEL_W'(FSEL_REGFILE);
        if (pending && !raw) begin
            fwd = FSEL_W'(FWD_STAGES + 1 - int'(cnt));
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrlr.sv
// Decode-stage hazard controller: per-register countdown scoreboard driving stall and bypass selects.
// Define HAZARD_STATS_EN to add the saturating o_stall_cycles counter.
module hazard_scoreboard_ctrlr
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 3,
    parameter int MAX_LAT    = DEFAULT_MAX_LAT,
    parameter int CNT_W      = $clog2(MAX_LAT + FWD_STAGES + 1),
    parameter int FSEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic                  i_kill,
    input  logic                  i_flush,
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_rt_addr,
    input  logic                  i_rs_used,
    input  logic                  i_rt_used,
    input  logic                  i_dst_we,
    input  logic [REG_ADDR_W-1:0] i_dst_addr,
    input  logic [CNT_W-1:0]      i_lat,
    output logic                  o_stall,
    output logic [FSEL_W-1:0]     o_rs_fwd,
    output logic [FSEL_W-1:0]     o_rt_fwd,
    output logic                  o_idle
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           o_stall_cycles
`endif
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic [FSEL_W-1:0] fwd [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] raw;

    logic [CNT_W-1:0] lat_clamped;
    logic [CNT_W-1:0] load_val;
    logic             rs_raw;
    logic             rt_raw;
    logic             waw;
    logic             issue;
    logic             load_en;

    // Illegal latencies are clamped rather than trusted
    assign lat_clamped = (i_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : i_lat;
    assign load_val    = lat_clamped + CNT_W'(FWD_STAGES);

    // Register 0 is hardwired: never pending, always read from the register file
    assign cnt[0]     = '0;
    assign fwd[0]     = FSEL_W'(FSEL_REGFILE);
    assign pending[0] = 1'b0;
    assign raw[0]     = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        hazard_sb_entry #(
            .FWD_STAGES (FWD_STAGES),
            .CNT_W      (CNT_W),
            .FSEL_W     (FSEL_W)
        ) u_entry (
            .clock    (clock),
            .reset    (reset),
            .flush    (i_flush),
            .load     (load_en && (i_dst_addr == REG_ADDR_W'(r))),
            .load_val (load_val),
            .cnt      (cnt[r]),
            .pending  (pending[r]),
            .raw      (raw[r]),
            .fwd      (fwd[r])
        );
    end

    assign rs_raw = i_rs_used && raw[i_rs_addr];
    assign rt_raw = i_rt_used && raw[i_rt_addr];
    // A younger write must not land before an older, slower write to the same register
    assign waw    = i_dst_we && (cnt[i_dst_addr] > load_val);

    assign o_stall  = i_valid && !i_kill && !i_flush && (rs_raw || rt_raw || waw);
    assign issue    = i_valid && !i_kill && !o_stall && !i_flush;
    assign load_en  = issue && i_dst_we && (i_dst_addr != '0);

    assign o_rs_fwd = i_rs_used ? fwd[i_rs_addr] : FSEL_W'(FSEL_REGFILE);
    assign o_rt_fwd = i_rt_used ? fwd[i_rt_addr] : FSEL_W'(FSEL_REGFILE);
    assign o_idle   = ~|pending;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_stall_cycles <= '0;
        end else if (o_stall && (o_stall_cycles != '1)) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
